// File: rtl/fetch_unit_if.sv
// Fetch unit signal bundle: redirect, MMU request/response and decode-side instruction stream.
// master is the fetch_unit side, slave is the surrounding core (MMU and decode).
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  redirect_valid_in;
  logic [ADDR_WIDTH-1:0] redirect_pc_in;

  logic                  fetch_request_valid_out;
  logic                  fetch_request_ready_in;
  logic [ADDR_WIDTH-1:0] fetch_request_address_out;

  logic                  fetch_response_valid_in;
  logic                  fetch_response_ready_out;
  logic [DATA_WIDTH-1:0] fetch_response_data_in;

  logic                  inst_valid_out;
  logic                  inst_ready_in;
  logic [DATA_WIDTH-1:0] inst_data_out;
  logic [ADDR_WIDTH-1:0] inst_pc_out;

  modport master (
    input  redirect_valid_in, redirect_pc_in,
    output fetch_request_valid_out, fetch_request_address_out,
    input  fetch_request_ready_in,
    input  fetch_response_valid_in, fetch_response_data_in,
    output fetch_response_ready_out,
    output inst_valid_out, inst_data_out, inst_pc_out,
    input  inst_ready_in
  );

  modport slave (
    output redirect_valid_in, redirect_pc_in,
    input  fetch_request_valid_out, fetch_request_address_out,
    output fetch_request_ready_in,
    output fetch_response_valid_in, fetch_response_data_in,
    input  fetch_response_ready_out,
    input  inst_valid_out, inst_data_out, inst_pc_out,
    output inst_ready_in
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, credit-limited word fetches, in-order response buffer, redirect flush.
// Requests only issue while inflight + buffered < FIFO_DEPTH, so responses always find FIFO space.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 4
) (
  input logic          clk_in,
  input logic          rst_in,
  fetch_unit_if.master bus
);
  localparam int                    CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int                    PW      = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0]         DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]         ONE_C   = CW'(1);
  localparam logic [PW-1:0]         PONE_C  = PW'(1);
  localparam logic [ADDR_WIDTH-1:0] STEP_C  = ADDR_WIDTH'(4);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0]         inflight_q, inflight_d, drop_q, drop_d, count_q, count_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] pc_mem_q  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] dat_mem_q [FIFO_DEPTH];

  logic                  redirect, req_vld, inst_vld;
  logic                  req_fire, resp_fire, push, pop;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  assign redirect    = bus.redirect_valid_in;
  assign redirect_pc = {bus.redirect_pc_in[ADDR_WIDTH-1:2], 2'b00};

  // Credit check uses registered state only, keeping inst_ready_in off the request path.
  assign req_vld   = ((inflight_q + count_q) < DEPTH_C) && !redirect;
  assign inst_vld  = (count_q != '0) && !redirect;
  assign req_fire  = req_vld && bus.fetch_request_ready_in && !rst_in;
  assign resp_fire = bus.fetch_response_valid_in && !rst_in;
  assign push      = resp_fire && (drop_q == '0) && !redirect;
  assign pop       = inst_vld && bus.inst_ready_in && !rst_in;

  assign bus.fetch_request_valid_out   = req_vld && !rst_in;
  assign bus.fetch_request_address_out = rst_in ? '0 : pc_q;
  assign bus.fetch_response_ready_out  = !rst_in;
  assign bus.inst_valid_out            = inst_vld && !rst_in;
  assign bus.inst_data_out             = rst_in ? '0 : dat_mem_q[rd_ptr_q];
  assign bus.inst_pc_out               = rst_in ? '0 : pc_mem_q[rd_ptr_q];

  always_comb begin
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (req_fire) begin
      pc_d       = pc_q + STEP_C;
      inflight_d = inflight_d + ONE_C;
    end
    if (resp_fire) begin
      inflight_d = inflight_d - ONE_C;
    end

    if (redirect) begin
      // A response firing this cycle is already excluded from inflight_d and is discarded.
      pc_d      = redirect_pc;
      resp_pc_d = redirect_pc;
      drop_d    = inflight_d;
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
    end else begin
      if (resp_fire) begin
        if (drop_q != '0) drop_d    = drop_q - ONE_C;
        else              resp_pc_d = resp_pc_q + STEP_C;
      end
      if (push) wr_ptr_d = wr_ptr_q + PONE_C;
      if (pop)  rd_ptr_d = rd_ptr_q + PONE_C;
      case ({push, pop})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]  <= resp_pc_q;
      dat_mem_q[wr_ptr_q] <= bus.fetch_response_data_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      assert (!(bus.fetch_response_valid_in && inflight_q == '0));
      assert ((inflight_q + count_q) <= DEPTH_C);
      assert (drop_q <= inflight_q);
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit with an in-order MMU model and a second instance for PC wrap.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wbus ();

  fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(4))
    dut (.clk_in(clk), .rst_in(rst), .bus(bus));
  fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4))
    wdut (.clk_in(clk), .rst_in(rst), .bus(wbus));

  typedef struct {
    bit          rf;      // reset before applying
    bit          irdy;
    bit          mrdy;
    bit          ren;     // MMU allowed to return its oldest pending response
    bit          redir;
    logic [31:0] rpc;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_inst;
    logic [31:0] e_pc;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] mq[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [31:0] dfun(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic void add(input bit rf, input bit irdy, input bit mrdy, input bit ren,
                              input bit redir, input logic [31:0] rpc,
                              input bit e_req, input logic [31:0] e_addr,
                              input bit e_inst, input logic [31:0] e_pc);
    vec_t v;
    v.rf = rf; v.irdy = irdy; v.mrdy = mrdy; v.ren = ren; v.redir = redir; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_inst = e_inst; v.e_pc = e_pc;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.inst_ready_in           = 1'b0;
    bus.fetch_request_ready_in  = 1'b0;
    bus.redirect_valid_in       = 1'b0;
    bus.redirect_pc_in          = '0;
    bus.fetch_response_valid_in = 1'b0;
    bus.fetch_response_data_in  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    mq.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Samples handshakes before the edge, updates the MMU queue just after it.
  task automatic cycle();
    bit          rq, rs;
    logic [31:0] a;
    @(negedge clk);
    rq = bus.fetch_request_valid_out && bus.fetch_request_ready_in;
    rs = bus.fetch_response_valid_in && bus.fetch_response_ready_out;
    a  = bus.fetch_request_address_out;
    @(posedge clk);
    #1;
    if (rs && mq.size() > 0) void'(mq.pop_front());
    if (rq) mq.push_back(a);
  endtask

  task automatic apply(input vec_t v, input int idx);
    if (v.rf) do_reset();
    bus.inst_ready_in           = v.irdy;
    bus.fetch_request_ready_in  = v.mrdy;
    bus.redirect_valid_in       = v.redir;
    bus.redirect_pc_in          = v.rpc;
    bus.fetch_response_valid_in = v.ren && (mq.size() > 0);
    bus.fetch_response_data_in  = (mq.size() > 0) ? dfun(mq[0]) : 32'h0;
    #1;
    chk($sformatf("v%0d req_vld", idx), 32'(bus.fetch_request_valid_out), 32'(v.e_req));
    if (v.e_req) chk($sformatf("v%0d req_addr", idx), bus.fetch_request_address_out, v.e_addr);
    chk($sformatf("v%0d inst_vld", idx), 32'(bus.inst_valid_out), 32'(v.e_inst));
    if (v.e_inst) begin
      chk($sformatf("v%0d inst_pc", idx), bus.inst_pc_out, v.e_pc);
      chk($sformatf("v%0d inst_data", idx), bus.inst_data_out, dfun(v.e_pc));
    end
    cycle();
  endtask

  initial begin
    logic [31:0] wexp[5];
    rst = 1'b1;
    drive_idle();
    wbus.inst_ready_in           = 1'b0;
    wbus.fetch_request_ready_in  = 1'b1;
    wbus.redirect_valid_in       = 1'b0;
    wbus.redirect_pc_in          = '0;
    wbus.fetch_response_valid_in = 1'b0;
    wbus.fetch_response_data_in  = '0;

    // rf irdy mrdy ren redir rpc | e_req e_addr | e_inst e_pc
    // Zero-wait MMU, decode always ready.
    add(1,1,1,1,0,0, 1,32'h00, 0,0);
    add(0,1,1,1,0,0, 1,32'h04, 0,0);
    add(0,1,1,1,0,0, 1,32'h08, 1,32'h00);
    add(0,1,1,1,0,0, 1,32'h0C, 1,32'h04);
    add(0,1,1,1,0,0, 1,32'h10, 1,32'h08);
    add(0,1,1,1,0,0, 1,32'h14, 1,32'h0C);
    // Decode stalled: four credits, then one more after a single pop.
    add(1,0,1,1,0,0, 1,32'h00, 0,0);
    add(0,0,1,1,0,0, 1,32'h04, 0,0);
    add(0,0,1,1,0,0, 1,32'h08, 1,32'h00);
    add(0,0,1,1,0,0, 1,32'h0C, 1,32'h00);
    add(0,0,1,1,0,0, 0,0,      1,32'h00);
    add(0,0,1,1,0,0, 0,0,      1,32'h00);
    add(0,1,1,1,0,0, 0,0,      1,32'h00);
    add(0,0,1,1,0,0, 1,32'h10, 1,32'h04);
    add(0,0,1,1,0,0, 0,0,      1,32'h04);
    add(0,0,1,1,0,0, 0,0,      1,32'h04);
    // Three in flight, redirect to an unaligned target.
    add(1,1,1,0,0,0,            1,32'h00,  0,0);
    add(0,1,1,0,0,0,            1,32'h04,  0,0);
    add(0,1,1,0,0,0,            1,32'h08,  0,0);
    add(0,1,1,0,1,32'h0000_0103, 0,0,      0,0);
    add(0,1,1,1,0,0,            1,32'h100, 0,0);
    add(0,1,1,1,0,0,            1,32'h104, 0,0);
    add(0,1,1,1,0,0,            1,32'h108, 0,0);
    add(0,1,1,1,0,0,            1,32'h10C, 0,0);
    add(0,1,1,1,0,0,            0,0,       1,32'h100);
    add(0,1,1,1,0,0,            1,32'h110, 1,32'h104);
    // Redirect coinciding with a response fire, two in flight.
    add(1,1,1,0,0,0,            1,32'h00,  0,0);
    add(0,1,1,0,0,0,            1,32'h04,  0,0);
    add(0,1,1,1,1,32'h0000_0200, 0,0,      0,0);
    add(0,1,1,1,0,0,            1,32'h200, 0,0);
    add(0,1,1,1,0,0,            1,32'h204, 0,0);
    add(0,1,1,1,0,0,            1,32'h208, 1,32'h200);
    // Build two buffered plus two in flight before a mid-stream reset.
    add(1,0,1,1,0,0, 1,32'h00, 0,0);
    add(0,0,1,1,0,0, 1,32'h04, 0,0);
    add(0,0,1,1,0,0, 1,32'h08, 1,32'h00);
    add(0,0,1,0,0,0, 1,32'h0C, 1,32'h00);

    // PC wrap on the second instance: no responses, so it stops after four credits.
    wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000;
    wexp[3] = 32'h0000_0004; wexp[4] = 32'h0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("wrap%0d req_vld", i), 32'(wbus.fetch_request_valid_out), (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) chk($sformatf("wrap%0d req_addr", i), wbus.fetch_request_address_out, wexp[i]);
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Asynchronous reset between edges: outputs must clear without a clock.
    rst = 1'b1;
    #1;
    chk("rst req_vld",   32'(bus.fetch_request_valid_out),  32'd0);
    chk("rst req_addr",  bus.fetch_request_address_out,     32'd0);
    chk("rst resp_rdy",  32'(bus.fetch_response_ready_out), 32'd0);
    chk("rst inst_vld",  32'(bus.inst_valid_out),           32'd0);
    chk("rst inst_data", bus.inst_data_out,                 32'd0);
    chk("rst inst_pc",   bus.inst_pc_out,                   32'd0);
    chk("rst wrap addr", wbus.fetch_request_address_out,    32'd0);
    drive_idle();
    mq.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("post req_vld",  32'(bus.fetch_request_valid_out),  32'd1);
    chk("post req_addr", bus.fetch_request_address_out,     32'd0);
    chk("post resp_rdy", 32'(bus.fetch_response_ready_out), 32'd1);
    chk("post inst_vld", 32'(bus.inst_valid_out),           32'd0);
    chk("post wrap addr", wbus.fetch_request_address_out,   32'hFFFF_FFF8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
